// File: rtl/debug_pkg.sv
// Shared encodings for the SNN debug probe: config field layout, mode codes and FSM states.
package debug_pkg;

  localparam int unsigned CFG_MODE_MSB = 7;
  localparam int unsigned CFG_MODE_LSB = 6;
  localparam int unsigned CFG_IDX_MSB  = 5;
  localparam int unsigned CFG_IDX_LSB  = 0;

  localparam logic [1:0] MODE_STATIC  = 2'b00;
  localparam logic [1:0] MODE_SCAN    = 2'b01;
  localparam logic [1:0] MODE_CAPTURE = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  typedef enum logic [1:0] {
    S_STATIC,
    S_SCAN,
    S_ARMED,
    S_HELD
  } state_e;

  function automatic state_e mode_to_state(logic [1:0] mode);
    case (mode)
      MODE_SCAN:    return S_SCAN;
      MODE_CAPTURE: return S_ARMED;
      default:      return S_STATIC;
    endcase
  endfunction

endpackage

// File: rtl/debug_chan_mux.sv
// Combinational channel select: membrane potential for idx < NumNeurons, else the spike vector.
module debug_chan_mux #(
  parameter int unsigned NumNeurons = 10,
  parameter int unsigned NBits      = 2,
  parameter int unsigned NSpikes    = 8,
  parameter int unsigned OutW       = 8
) (
  input  logic [5:0]                  idx_i,
  input  logic [NumNeurons*NBits-1:0] pots_i,
  input  logic [NSpikes-1:0]          spikes_i,
  output logic [OutW-1:0]             data_o
);

  always_comb begin
    data_o = OutW'(spikes_i);
    for (int unsigned i = 0; i < NumNeurons; i++) begin
      if (32'(idx_i) == i) begin
        data_o = OutW'(pots_i[i*NBits +: NBits]);
      end
    end
  end

endmodule

// File: rtl/debug_scan_probe.sv
// Debug probe: static channel select, timed auto-scan, or spike-triggered snapshot capture.
module debug_scan_probe
  import debug_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 10,
  parameter int unsigned NBITS       = 2,
  parameter int unsigned NSPIKES     = 8,
  parameter int unsigned OUT_W       = 8,
  parameter int unsigned DWELL       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [7:0]                   debug_config_in,
  input  logic [NUM_NEURONS*NBITS-1:0] membrane_potentials,
  input  logic [NSPIKES-1:0]           output_spikes_layer1,
  output logic [OUT_W-1:0]             debug_select,
  output logic [7:0]                   debug_chan,
  output logic                         debug_valid,
  output logic                         debug_frame
);

  localparam int unsigned DwW = (DWELL > 1) ? $clog2(DWELL) : 1;

  if (NBITS > OUT_W || NSPIKES > OUT_W || DWELL < 1) begin : g_param_err
    $error("debug_scan_probe: NBITS/NSPIKES must fit OUT_W and DWELL must be >= 1");
  end

  logic [7:0]       cfg_q, cfg_d;
  state_e           state_q, state_d;
  logic [7:0]       scan_chan_q, scan_chan_d;
  logic [DwW-1:0]   dwell_q, dwell_d;
  logic [OUT_W-1:0] sel_q, sel_d;
  logic [7:0]       chan_q, chan_d;
  logic             valid_q, valid_d;
  logic             frame_q, frame_d;

  logic [1:0]       cfg_mode;
  logic [5:0]       cfg_idx;
  logic [5:0]       mux_idx;
  logic [7:0]       chan_num;
  logic [OUT_W-1:0] mux_data;
  logic             trig;
  logic             dwell_last;
  logic             scan_last;

  assign cfg_mode   = cfg_q[CFG_MODE_MSB:CFG_MODE_LSB];
  assign cfg_idx    = cfg_q[CFG_IDX_MSB:CFG_IDX_LSB];
  assign trig       = |output_spikes_layer1;
  assign dwell_last = (dwell_q == DwW'(DWELL - 1));
  assign scan_last  = (scan_chan_q == 8'(NUM_NEURONS));

  // Reserved mode pins the static selection to the spike slot.
  always_comb begin
    if (state_q == S_SCAN) begin
      mux_idx = scan_chan_q[5:0];
    end else if (cfg_mode == MODE_RSVD) begin
      mux_idx = 6'(NUM_NEURONS);
    end else begin
      mux_idx = cfg_idx;
    end
  end

  assign chan_num = (32'(mux_idx) < NUM_NEURONS) ? {2'b00, mux_idx} : 8'(NUM_NEURONS);

  debug_chan_mux #(
    .NumNeurons (NUM_NEURONS),
    .NBits      (NBITS),
    .NSpikes    (NSPIKES),
    .OutW       (OUT_W)
  ) u_chan_mux (
    .idx_i    (mux_idx),
    .pots_i   (membrane_potentials),
    .spikes_i (output_spikes_layer1),
    .data_o   (mux_data)
  );

  // Control state: a config write takes priority over dwell expiry and triggers.
  always_comb begin
    cfg_d       = cfg_q;
    state_d     = state_q;
    scan_chan_d = scan_chan_q;
    dwell_d     = dwell_q;
    if (en) begin
      cfg_d       = debug_config_in;
      state_d     = mode_to_state(debug_config_in[CFG_MODE_MSB:CFG_MODE_LSB]);
      scan_chan_d = '0;
      dwell_d     = '0;
    end else begin
      case (state_q)
        S_SCAN: begin
          if (dwell_last) begin
            dwell_d     = '0;
            scan_chan_d = scan_last ? 8'd0 : scan_chan_q + 8'd1;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        S_ARMED: if (trig) state_d = S_HELD;
        default: ;
      endcase
    end
  end

  // Output registers follow the current state; outputs reflect a new config one edge after load.
  always_comb begin
    sel_d   = sel_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    frame_d = 1'b0;
    case (state_q)
      S_STATIC: begin
        sel_d   = mux_data;
        chan_d  = chan_num;
        valid_d = 1'b1;
      end
      S_SCAN: begin
        sel_d   = mux_data;
        chan_d  = chan_num;
        valid_d = 1'b1;
        frame_d = (scan_chan_q == 8'd0) && (dwell_q == '0);
      end
      S_ARMED: begin
        sel_d   = mux_data;
        chan_d  = chan_num;
        valid_d = trig && !en;
      end
      S_HELD: begin
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q       <= '0;
      state_q     <= S_STATIC;
      scan_chan_q <= '0;
      dwell_q     <= '0;
      sel_q       <= '0;
      chan_q      <= '0;
      valid_q     <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      cfg_q       <= cfg_d;
      state_q     <= state_d;
      scan_chan_q <= scan_chan_d;
      dwell_q     <= dwell_d;
      sel_q       <= sel_d;
      chan_q      <= chan_d;
      valid_q     <= valid_d;
      frame_q     <= frame_d;
    end
  end

  assign debug_select = sel_q;
  assign debug_chan   = chan_q;
  assign debug_valid  = valid_q;
  assign debug_frame  = frame_q;

endmodule
